// File: rtl/cq_pkg.sv
// Shared definitions for the commit-queue tracker and the tag-routing decoder.
//   TAG_W        tag width (8-bit, wrapping)
//   CQ_SIZE      default queue depth
//   IDX_W        width of a slot index / occupancy value (covers depth 1..16)
//   tag_t        tag type
//   onehot_index index of the lowest set bit of a one-hot slot vector
package cq_pkg;

  localparam int TAG_W   = 8;
  localparam int CQ_SIZE = 4;
  localparam int IDX_W   = 5;
  localparam int MAX_SLOTS = 16;

  typedef logic [TAG_W-1:0] tag_t;

  // Lowest set bit wins, so a malformed multi-hot vector still flushes
  // from the oldest flagged slot. An all-zero vector returns 0; callers
  // must qualify with a reduction-OR.
  function automatic logic [IDX_W-1:0] onehot_index(input logic [MAX_SLOTS-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cq_slot_vector.sv
// Per-slot done bits of the commit queue, slot 0 = oldest.
//   clk, rst     clock / asynchronous active-high reset
//   set_i        completion vector (OR of all take vectors)
//   cnt_i        current occupancy; sets at or above it are ignored
//   shift_i      retire: shift toward slot 0, top slot cleared
//   cnt_next_i   occupancy after this cycle; bits at or above it are cleared
//   done_o       registered done bits
module cq_slot_vector
  import cq_pkg::*;
#(
  parameter int SIZE = CQ_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIZE-1:0]  set_i,
  input  logic [IDX_W-1:0] cnt_i,
  input  logic             shift_i,
  input  logic [IDX_W-1:0] cnt_next_i,
  output logic [SIZE-1:0]  done_o
);

  logic [SIZE-1:0] done_q;
  logic [SIZE-1:0] done_d;

  // Completions merge before the retire shift, so a take on slot i lands at
  // i-1 and a take on slot 0 is dropped with the retiring op. Masking with
  // the next occupancy clears killed slots and keeps every unoccupied bit at
  // 0, which means a freshly allocated slot always starts not-done.
  always_comb begin
    done_d = done_q;
    for (int i = 0; i < SIZE; i++) begin
      if (set_i[i] && (IDX_W'(i) < cnt_i)) done_d[i] = 1'b1;
    end
    if (shift_i) done_d = done_d >> 1;
    for (int i = 0; i < SIZE; i++) begin
      if (IDX_W'(i) >= cnt_next_i) done_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= '0;
    else     done_q <= done_d;
  end

  assign done_o = done_q;

endmodule

// File: rtl/cq_completion_tracker.sv
// In-order commit queue tracker. Hands out sequential 8-bit tags, records
// completions, retires in order and advances newBase, flushes on kill.
//   clk, reset            clock / asynchronous active-high reset
//   allocValid/Ready/Tag  dispatch handshake; tag = newBase+1+count
//   takeA..takeD          one-hot completion vectors, bit 0 = oldest slot
//   kill, execEventSignal one-hot flush point, qualified by the event
//   newBase               tag of the last retired op
//   retireValid/Ready/Tag commit handshake; tag = newBase+1
//   count                 occupied slots
module cq_completion_tracker
  import cq_pkg::*;
#(
  parameter int SIZE = CQ_SIZE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       allocValid,
  output logic                       allocReady,
  output logic [TAG_W-1:0]           allocTag,
  input  logic [SIZE-1:0]            takeA,
  input  logic [SIZE-1:0]            takeB,
  input  logic [SIZE-1:0]            takeC,
  input  logic [SIZE-1:0]            takeD,
  input  logic [SIZE-1:0]            kill,
  input  logic                       execEventSignal,
  output logic [TAG_W-1:0]           newBase,
  output logic                       retireValid,
  input  logic                       retireReady,
  output logic [TAG_W-1:0]           retireTag,
  output logic [$clog2(SIZE+1)-1:0]  count
);

  localparam int CW = $clog2(SIZE + 1);

  tag_t            newBase_q, newBase_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SIZE-1:0] done;
  logic [SIZE-1:0] take_any;
  logic            kill_act;
  logic [IDX_W-1:0] kill_j;
  logic            alloc_fire, ret_fire;
  logic [IDX_W-1:0] cnt_ext, cnt_after_ret, clr_from, cnt_next;

  assign take_any = takeA | takeB | takeC | takeD;
  assign kill_act = execEventSignal & (|kill);
  assign kill_j   = onehot_index(MAX_SLOTS'(kill));
  assign cnt_ext  = IDX_W'(count_q);

  // A flush at slot 0 takes the head with it, so it must not retire.
  assign retireValid = (count_q != '0) & done[0] & ~(kill_act & (kill_j == '0));
  assign retireTag   = newBase_q + 8'd1;
  assign ret_fire    = retireValid & retireReady;

  // Full stays full even if the head retires this cycle.
  assign allocReady = (count_q < CW'(SIZE)) & ~kill_act;
  assign allocTag   = newBase_q + 8'd1 + TAG_W'(count_q);
  assign alloc_fire = allocValid & allocReady;

  // The kill index is relative to the pre-retire slots; when the head
  // retires in the same cycle everything moves down one, so the cut does too.
  // ret_fire is 0 whenever kill_j is 0, so clr_from cannot underflow.
  always_comb begin
    cnt_after_ret = cnt_ext - IDX_W'(ret_fire);
    clr_from      = kill_j - IDX_W'(ret_fire);
    cnt_next      = cnt_after_ret + IDX_W'(alloc_fire);
    if (kill_act && (clr_from < cnt_after_ret)) cnt_next = clr_from;
    count_d   = CW'(cnt_next);
    newBase_d = newBase_q + TAG_W'(ret_fire);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      newBase_q <= '0;
      count_q   <= '0;
    end else begin
      newBase_q <= newBase_d;
      count_q   <= count_d;
    end
  end

  cq_slot_vector #(.SIZE(SIZE)) u_slots (
    .clk        (clk),
    .rst        (reset),
    .set_i      (take_any),
    .cnt_i      (cnt_ext),
    .shift_i    (ret_fire),
    .cnt_next_i (cnt_next),
    .done_o     (done)
  );

  assign newBase = newBase_q;
  assign count   = count_q;

endmodule
